// File: rtl/keypad_operand_sequencer.sv
// keypad_operand_sequencer: turns debounced key codes into two BCD operands and a multiply request.
// Latency: a key event acts on the edge where it is detected; every output reflects it one cycle later.
// Backpressure: start is held off in WAIT_START until mult_ready; keys that cannot be accepted pulse key_err.
module keypad_operand_sequencer #(
  parameter int N_DIGITS = 2,
  parameter int CNT_W    = $clog2(N_DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  mult_ready,
  input  logic                  mult_done,
  output logic [4*N_DIGITS-1:0] operand_a,
  output logic [4*N_DIGITS-1:0] operand_b,
  output logic [CNT_W-1:0]      a_count,
  output logic [CNT_W-1:0]      b_count,
  output logic                  start,
  output logic                  busy,
  output logic                  key_err,
  output logic [2:0]            state_o
);

  localparam int W = 4 * N_DIGITS;

  localparam logic [3:0] K_STAR  = 4'hA;
  localparam logic [3:0] K_EQUAL = 4'hB;
  localparam logic [3:0] K_CLEAR = 4'hC;
  localparam logic [3:0] K_BKSP  = 4'hD;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Encoding is visible on state_o, so the values are fixed for the display path.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ENTER_A    = 3'd1,
    S_ENTER_B    = 3'd2,
    S_WAIT_START = 3'd3,
    S_BUSY       = 3'd4,
    S_RESULT     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             key_prev_q;
  logic [W-1:0]     operand_a_q, operand_a_d;
  logic [W-1:0]     operand_b_q, operand_b_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
  logic             start_q, start_d;
  logic             key_err_q, key_err_d;

  logic key_evt;
  logic key_is_digit;
  logic a_full;
  logic b_full;

  // Shift a new digit in at the least significant position; the oldest digit falls off the top.
  function automatic logic [W-1:0] push_digit(input logic [W-1:0] op, input logic [3:0] d);
    return W'({op, d});
  endfunction

  // Drop the least significant digit; zeros fill in from the top.
  function automatic logic [W-1:0] pop_digit(input logic [W-1:0] op);
    return op >> 4;
  endfunction

  // A press is the rising edge of key_valid, so a held key produces exactly one event.
  assign key_evt      = key_valid & ~key_prev_q;
  assign key_is_digit = (key_code <= 4'h9);
  assign a_full       = (a_cnt_q == CNT_MAX);
  assign b_full       = (b_cnt_q == CNT_MAX);

  // State, operands, counters and the one-cycle pulses; reset clears everything, including a pending start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      key_prev_q  <= 1'b0;
      operand_a_q <= '0;
      operand_b_q <= '0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      start_q     <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_prev_q  <= key_valid;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      start_q     <= start_d;
      key_err_q   <= key_err_d;
    end
  end

  // Next-state and datapath decode: each state decides which key events it accepts.
  always_comb begin
    state_d     = state_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    a_cnt_d     = a_cnt_q;
    b_cnt_d     = b_cnt_q;
    start_d     = 1'b0;
    key_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_evt) begin
          if (key_is_digit) begin
            // First digit of a fresh calculation: wipe both operands.
            operand_a_d = W'(key_code);
            operand_b_d = '0;
            a_cnt_d     = CNT_ONE;
            b_cnt_d     = '0;
            state_d     = S_ENTER_A;
          end else begin
            key_err_d = 1'b1;
          end
        end
      end

      S_ENTER_A: begin
        if (key_evt) begin
          if (key_is_digit) begin
            if (a_full) begin
              key_err_d = 1'b1;
            end else begin
              operand_a_d = push_digit(operand_a_q, key_code);
              a_cnt_d     = a_cnt_q + CNT_ONE;
            end
          end else begin
            case (key_code)
              K_BKSP: begin
                operand_a_d = pop_digit(operand_a_q);
                // Deleting the last digit of A means nothing is entered any more.
                if (a_cnt_q <= CNT_ONE) begin
                  a_cnt_d = '0;
                  state_d = S_IDLE;
                end else begin
                  a_cnt_d = a_cnt_q - CNT_ONE;
                end
              end
              K_STAR: begin
                operand_b_d = '0;
                b_cnt_d     = '0;
                state_d     = S_ENTER_B;
              end
              K_CLEAR: begin
                operand_a_d = '0;
                a_cnt_d     = '0;
                state_d     = S_IDLE;
              end
              default: key_err_d = 1'b1;
            endcase
          end
        end
      end

      S_ENTER_B: begin
        if (key_evt) begin
          if (key_is_digit) begin
            if (b_full) begin
              key_err_d = 1'b1;
            end else begin
              operand_b_d = push_digit(operand_b_q, key_code);
              b_cnt_d     = b_cnt_q + CNT_ONE;
            end
          end else begin
            case (key_code)
              K_BKSP: begin
                if (b_cnt_q != '0) begin
                  operand_b_d = pop_digit(operand_b_q);
                  b_cnt_d     = b_cnt_q - CNT_ONE;
                end else begin
                  // Backing out of an empty B returns to editing A, which is untouched.
                  state_d = S_ENTER_A;
                end
              end
              K_EQUAL: begin
                if (b_cnt_q != '0) begin
                  state_d = S_WAIT_START;
                end else begin
                  key_err_d = 1'b1;
                end
              end
              K_CLEAR: begin
                operand_a_d = '0;
                operand_b_d = '0;
                a_cnt_d     = '0;
                b_cnt_d     = '0;
                state_d     = S_IDLE;
              end
              default: key_err_d = 1'b1;
            endcase
          end
        end
      end

      S_WAIT_START: begin
        // Clear has priority over a ready multiplier so an aborted request never starts.
        if (key_evt && (key_code == K_CLEAR)) begin
          state_d = S_IDLE;
        end else begin
          if (key_evt) begin
            key_err_d = 1'b1;
          end
          if (mult_ready) begin
            start_d = 1'b1;
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        // Operands stay frozen; every key is rejected, even one arriving with mult_done.
        if (mult_done) begin
          state_d = S_RESULT;
        end
        if (key_evt) begin
          key_err_d = 1'b1;
        end
      end

      S_RESULT: begin
        if (key_evt) begin
          if (key_is_digit) begin
            operand_a_d = W'(key_code);
            operand_b_d = '0;
            a_cnt_d     = CNT_ONE;
            b_cnt_d     = '0;
            state_d     = S_ENTER_A;
          end else if (key_code == K_CLEAR) begin
            state_d = S_IDLE;
          end else begin
            key_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign operand_a = operand_a_q;
  assign operand_b = operand_b_q;
  assign a_count   = a_cnt_q;
  assign b_count   = b_cnt_q;
  assign start     = start_q;
  assign key_err   = key_err_q;
  assign busy      = (state_q == S_WAIT_START) || (state_q == S_BUSY);
  assign state_o   = state_q;

endmodule

// File: doc/keypad_operand_sequencer.md
Name: keypad_operand_sequencer

Overview:
- Parametrised keypad front-end for the Booth multiplier calculator.
- Turns debounced key codes into two BCD operands of up to N_DIGITS digits each, plus a multiply request.
- Supports backspace and clear, and handles the start/done handshake with the multiplier core.
- Sits between the keypad debouncer/encoder and the multiplier/display path.

Parameters:
- N_DIGITS, 2, maximum decimal digits per operand (1..8).
- CNT_W, $clog2(N_DIGITS+1), width of the digit counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- key_valid  in  1  level-high while a debounced key is held
- key_code  in  4  key code: 0x0-0x9 digit, 0xA '*', 0xB '=', 0xC clear, 0xD backspace, 0xE-0xF invalid
- mult_ready  in  1  multiplier idle, can accept start
- mult_done  in  1  one-cycle pulse, product valid
- operand_a  out  4*N_DIGITS  BCD operand A, least significant digit in [3:0]
- operand_b  out  4*N_DIGITS  BCD operand B, same layout as A
- a_count  out  CNT_W  digits entered in A
- b_count  out  CNT_W  digits entered in B
- start  out  1  one-cycle pulse requesting a multiply
- busy  out  1  high in WAIT_START and BUSY
- key_err  out  1  one-cycle pulse when a key event is rejected
- state_o  out  3  current state encoding, for display and debug

Behaviour:
- Reset: all outputs 0, state IDLE, key_prev 0.
- Key event:
  - A key event is registered when key_valid=1 and key_prev=0.
  - key_prev <= key_valid every cycle.
  - Only one event per press; a held key never repeats.
  - The event acts on the same clock edge it is detected; outputs update the next cycle.
- Digit append, for the operand being entered: operand <= {operand[4*N_DIGITS-5:0], digit}; count++.
  - If count==N_DIGITS, the digit is dropped, the operand is unchanged and key_err pulses.
- Backspace: operand <= {4'h0, operand[4*N_DIGITS-1:4]}; count--.
- State encoding: IDLE=0, ENTER_A=1, ENTER_B=2, WAIT_START=3, BUSY=4, RESULT=5.
- IDLE:
  - digit -> clear A/B and counts, append digit to A, go ENTER_A.
  - Any other key -> key_err, stay in IDLE.
- ENTER_A:
  - digit -> append to A.
  - backspace -> delete from A; if a_count becomes 0, go IDLE.
  - '*' -> clear B, go ENTER_B.
  - '=' -> key_err.
  - clear -> go IDLE and zero A.
- ENTER_B:
  - digit -> append to B.
  - backspace with b_count>0 -> delete from B.
  - backspace with b_count==0 -> return to ENTER_A with A intact.
  - '=' with b_count>=1 -> go WAIT_START.
  - '=' with b_count==0 -> key_err.
  - '*' -> key_err.
  - clear -> go IDLE and zero A and B.
- WAIT_START:
  - When mult_ready=1, pulse start for exactly one cycle and go BUSY.
  - clear -> abort to IDLE with no start; other keys -> key_err.
  - If clear and mult_ready=1 arrive together, clear wins: no start.
- BUSY:
  - Operands are frozen.
  - mult_done -> go RESULT.
  - All keys, including clear, -> key_err.
  - If mult_done and a key event arrive together, mult_done wins and the key is dropped with key_err.
- RESULT:
  - Operands are held for display.
  - digit -> zero A/B, load digit into A, go ENTER_A.
  - clear -> go IDLE.
  - Other keys -> key_err.
- Invalid codes 0xE/0xF -> key_err in every state; no state change.
- mult_done outside BUSY is ignored.
- start is never asserted outside the WAIT_START->BUSY transition.
- Reset mid-operation: immediate return to IDLE with all outputs 0.
  - A start pulse in flight is cut.
  - The multiplier is reset separately.

Test Plan:
- N_DIGITS=2: keys 4,7,'*',1,2,'=' with mult_ready=1 -> operand_a=8'h47, operand_b=8'h12, single start pulse, busy=1; mult_done -> state RESULT.
- Keys 9,9,5 -> operand_a=8'h99, a_count=2, key_err pulse on '5'.
- Key held high for 50 cycles -> exactly one digit appended.
- Keys 3,'*',backspace,backspace -> state ENTER_A then IDLE, a_count=0, operand_a=0.
- '=' with mult_ready=0 for 10 cycles, then clear -> no start ever; state IDLE.
- BUSY: clear and mult_done in the same cycle -> RESULT, operands held, key_err=1; then assert rst low mid-ENTER_B -> all outputs 0, state IDLE.
